// File: rtl/rx_engine.sv
// rx_engine: oversampling UART receiver (8N1) feeding an RX FIFO.
// Detects the start edge, samples mid-bit, and flags framing and overrun errors.
module rx_engine #(
   parameter int OSR = 16
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       osr_tick_i,
   input  logic       rx_i,
   input  logic       rx_en_i,
   input  logic       rx_fifo_full_i,
   output logic       rx_fifo_wen_o,
   output logic [7:0] rx_fifo_data_o,
   output logic       rx_busy_o,
   output logic       frame_err_o,
   output logic       overrun_err_o
);
   localparam int CW = $clog2(OSR);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
   state_t        state;
   logic          rx_q, rx_s;
   logic [CW-1:0] tick_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_q;
   logic          mid_tick, last_tick;
   assign mid_tick  = tick_cnt == CW'(OSR / 2 - 1);
   assign last_tick = tick_cnt == CW'(OSR - 1);
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         rx_q <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_q <= rx_i;
         rx_s <= rx_q;
      end
   end
   // rx_en_i only gates start detection, so a frame in flight always completes
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state          <= IDLE;
         tick_cnt       <= '0;
         bit_idx        <= '0;
         shift_q        <= '0;
         rx_fifo_wen_o  <= 1'b0;
         rx_fifo_data_o <= '0;
         rx_busy_o      <= 1'b0;
         frame_err_o    <= 1'b0;
         overrun_err_o  <= 1'b0;
      end else begin
         rx_fifo_wen_o <= 1'b0;
         frame_err_o   <= 1'b0;
         overrun_err_o <= 1'b0;
         if (osr_tick_i) begin
            tick_cnt <= tick_cnt + 1'b1;
            case (state)
               IDLE: if (rx_en_i && !rx_s) begin
                  tick_cnt  <= '0;
                  state     <= START;
                  rx_busy_o <= 1'b1;
               end
               START: if (mid_tick) begin
                  tick_cnt <= '0;
                  bit_idx  <= '0;
                  if (!rx_s) state <= DATA;
                  else begin
                     state     <= IDLE;
                     rx_busy_o <= 1'b0;
                  end
               end
               DATA: if (last_tick) begin
                  tick_cnt <= '0;
                  shift_q  <= {rx_s, shift_q[7:1]};
                  bit_idx  <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
               STOP: if (last_tick) begin
                  tick_cnt <= '0;
                  if (rx_s) begin
                     state     <= IDLE;
                     rx_busy_o <= 1'b0;
                     if (rx_fifo_full_i) overrun_err_o <= 1'b1;
                     else begin
                        rx_fifo_wen_o  <= 1'b1;
                        rx_fifo_data_o <= shift_q;
                     end
                  end else begin
                     state       <= BREAK;
                     frame_err_o <= 1'b1;
                  end
               end
               BREAK: if (rx_s) begin
                  state     <= IDLE;
                  rx_busy_o <= 1'b0;
               end
               default: begin
                  state     <= IDLE;
                  rx_busy_o <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rx_engine.sv
// tb_rx_engine: scoreboard bench for rx_engine at OSR=16 with a tick every 11 clocks.
module tb_rx_engine;
   localparam int OSR = 16;
   localparam logic [1:0] K_WR = 2'd1, K_FE = 2'd2, K_OV = 2'd3;
   logic       clk_i = 1'b0, reset_ni = 1'b0, osr_tick_i = 1'b0, rx_i = 1'b1;
   logic       rx_en_i = 1'b1, rx_fifo_full_i = 1'b0;
   logic       rx_fifo_wen_o, rx_busy_o, frame_err_o, overrun_err_o;
   logic [7:0] rx_fifo_data_o;
   int         compared = 0, mismatched = 0, tick_div = 0;
   logic [9:0] exp_q[$];
   logic [9:0] got, exp_ev;

   rx_engine #(.OSR(OSR)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .osr_tick_i(osr_tick_i), .rx_i(rx_i),
      .rx_en_i(rx_en_i), .rx_fifo_full_i(rx_fifo_full_i), .rx_fifo_wen_o(rx_fifo_wen_o),
      .rx_fifo_data_o(rx_fifo_data_o), .rx_busy_o(rx_busy_o), .frame_err_o(frame_err_o),
      .overrun_err_o(overrun_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial forever begin
      @(negedge clk_i);
      osr_tick_i = (tick_div == 10);
      tick_div = (tick_div == 10) ? 0 : tick_div + 1;
   end

   // every output pulse is matched against the next expected event
   always @(negedge clk_i) begin
      if (reset_ni) begin
         if (rx_fifo_wen_o && (frame_err_o || overrun_err_o)) begin
            compared++;
            mismatched++;
            $display("FAIL exclusive: wen=%b fe=%b ov=%b together", rx_fifo_wen_o, frame_err_o, overrun_err_o);
         end
         if (rx_fifo_wen_o || frame_err_o || overrun_err_o) begin
            got = {rx_fifo_wen_o ? K_WR : frame_err_o ? K_FE : K_OV, rx_fifo_wen_o ? rx_fifo_data_o : 8'h00};
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_event: got %h expected none", got);
            end else begin
               exp_ev = exp_q.pop_front();
               if (got !== exp_ev) begin
                  mismatched++;
                  $display("FAIL event: got %h expected %h", got, exp_ev);
               end
            end
         end
      end
   end

   task automatic wait_ticks(input int n);
      repeat (n) begin
         do @(posedge clk_i); while (!osr_tick_i);
      end
      @(negedge clk_i);
   endtask

   task automatic send_bits(input logic [7:0] d, input logic stop, input int stop_bits);
      rx_i = 1'b0;
      wait_ticks(OSR);
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         wait_ticks(OSR);
      end
      rx_i = stop;
      wait_ticks(OSR * stop_bits);
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_bits(d, 1'b1, 1);
   endtask

   task automatic check_drained(input string name);
      wait_ticks(4);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL %s: got %0d pending events expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset;
      reset_ni = 1'b0;
      repeat (5) @(negedge clk_i);
      compared++;
      if ({rx_fifo_wen_o, rx_busy_o, frame_err_o, overrun_err_o} !== 4'b0) begin
         mismatched++;
         $display("FAIL reset_flags: got %b expected 0000", {rx_fifo_wen_o, rx_busy_o, frame_err_o, overrun_err_o});
      end
      compared++;
      if (rx_fifo_data_o !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_data: got %h expected 00", rx_fifo_data_o);
      end
      reset_ni = 1'b1;
      wait_ticks(2);
   endtask

   task automatic test_single;
      exp_q.push_back({K_WR, 8'hA5});
      send_frame(8'hA5);
      check_drained("single_drain");
      compared++;
      if (rx_busy_o !== 1'b0) begin
         mismatched++;
         $display("FAIL single_busy: got %b expected 0", rx_busy_o);
      end
      compared++;
      if (rx_fifo_data_o !== 8'hA5) begin
         mismatched++;
         $display("FAIL single_hold: got %h expected a5", rx_fifo_data_o);
      end
   endtask

   task automatic test_false_start;
      rx_i = 1'b0;
      wait_ticks(4);
      compared++;
      if (rx_busy_o !== 1'b1) begin
         mismatched++;
         $display("FAIL false_start_busy: got %b expected 1", rx_busy_o);
      end
      rx_i = 1'b1;
      wait_ticks(OSR / 2);
      compared++;
      if (rx_busy_o !== 1'b0) begin
         mismatched++;
         $display("FAIL false_start_idle: got %b expected 0", rx_busy_o);
      end
      check_drained("false_start_drain");
   endtask

   task automatic test_frame_err;
      exp_q.push_back({K_FE, 8'h00});
      send_bits(8'h3C, 1'b0, 3);
      compared++;
      if (rx_busy_o !== 1'b1) begin
         mismatched++;
         $display("FAIL break_hold: got %b expected 1", rx_busy_o);
      end
      rx_i = 1'b1;
      wait_ticks(2);
      compared++;
      if (rx_busy_o !== 1'b0) begin
         mismatched++;
         $display("FAIL break_exit: got %b expected 0", rx_busy_o);
      end
      check_drained("frame_err_drain");
      exp_q.push_back({K_WR, 8'h3C});
      send_frame(8'h3C);
      check_drained("after_break_drain");
   endtask

   task automatic test_overrun;
      rx_fifo_full_i = 1'b1;
      exp_q.push_back({K_OV, 8'h00});
      send_frame(8'h55);
      check_drained("overrun_drain");
      rx_fifo_full_i = 1'b0;
      compared++;
      if (rx_fifo_data_o !== 8'h3C) begin
         mismatched++;
         $display("FAIL overrun_hold: got %h expected 3c", rx_fifo_data_o);
      end
   endtask

   task automatic test_back_to_back;
      exp_q.push_back({K_WR, 8'h01});
      exp_q.push_back({K_WR, 8'hFE});
      send_frame(8'h01);
      send_frame(8'hFE);
      check_drained("b2b_drain");
   endtask

   task automatic test_disable_mid_frame;
      exp_q.push_back({K_WR, 8'hC3});
      fork
         send_frame(8'hC3);
         begin
            wait_ticks(40);
            rx_en_i = 1'b0;
         end
      join
      check_drained("disable_drain");
      rx_i = 1'b0;
      wait_ticks(20);
      compared++;
      if (rx_busy_o !== 1'b0) begin
         mismatched++;
         $display("FAIL disabled_ignore: got %b expected 0", rx_busy_o);
      end
      rx_i = 1'b1;
      rx_en_i = 1'b1;
      wait_ticks(2);
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] d;
      d = 8'h96;
      rx_i = 1'b0;
      wait_ticks(OSR);
      for (int i = 0; i < 3; i++) begin
         rx_i = d[i];
         wait_ticks(OSR);
      end
      rx_i = d[3];
      wait_ticks(OSR / 2);
      compared++;
      if (rx_busy_o !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_busy: got %b expected 1", rx_busy_o);
      end
      reset_ni = 1'b0;
      #1;
      compared++;
      if ({rx_fifo_wen_o, rx_busy_o, frame_err_o, overrun_err_o, rx_fifo_data_o} !== 12'h000) begin
         mismatched++;
         $display("FAIL mid_reset_outputs: got %h expected 000", {rx_fifo_wen_o, rx_busy_o, frame_err_o, overrun_err_o, rx_fifo_data_o});
      end
      repeat (5) @(negedge clk_i);
      rx_i = 1'b1;
      reset_ni = 1'b1;
      wait_ticks(3);
      compared++;
      if (rx_busy_o !== 1'b0) begin
         mismatched++;
         $display("FAIL post_reset_idle: got %b expected 0", rx_busy_o);
      end
      exp_q.push_back({K_WR, 8'h96});
      send_frame(8'h96);
      check_drained("post_reset_drain");
      compared++;
      if (rx_fifo_data_o !== 8'h96) begin
         mismatched++;
         $display("FAIL post_reset_data: got %h expected 96", rx_fifo_data_o);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_disable_mid_frame();
      test_reset_mid_frame();
      wait_ticks(OSR);
      check_drained("final_drain");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
